// File: rtl/term_write_ctrl.sv
// Character-write controller: accepts a PIA character, writes it at the cursor slot,
// advances the cursor and requests scrolls. Optional cursor blink under `CURSOR_BLINK_EN`.
module term_write_ctrl #(
  parameter int unsigned COLS         = 40,
  parameter int unsigned ROWS         = 24,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       da,
  input  logic [6:0] din,
  input  logic       cursor_slot,
  input  logic       line_end,
  input  logic       scroll_done,
  input  logic       clr_scr,
  input  logic       frame_tick,
  output logic       rda,
  output logic       wr_en,
  output logic [6:0] wr_data,
  output logic [5:0] cur_col,
  output logic [4:0] cur_row,
  output logic       scroll,
  output logic       clr_busy,
  output logic       cursor_vis
);

  typedef enum logic [2:0] {
    IDLE, WAIT_SLOT, WRITE, ADVANCE, SCROLL_WAIT, CLEAR
  } state_t;

  localparam int unsigned   CNT_W    = $clog2(ROWS + 1);
  localparam logic [5:0]    COL_LAST = 6'(COLS - 1);
  localparam logic [4:0]    ROW_LAST = 5'(ROWS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROWS - 1);

  state_t           state, state_d;
  logic             da_q;
  logic             nl_q, nl_d;
  logic [6:0]       char_q, char_d;
  logic [CNT_W-1:0] clr_cnt, clr_cnt_d;
  logic             rda_d, wr_en_d, scroll_d, clr_busy_d;
  logic [6:0]       wr_data_d;
  logic [5:0]       col_d;
  logic [4:0]       row_d;
  logic             accept;

  // rda gating keeps a da level held through reset release from being taken as a rise
  assign accept = (state == IDLE) && rda && da && !da_q;

  always_comb begin
    state_d    = state;
    nl_d       = nl_q;
    char_d     = char_q;
    clr_cnt_d  = clr_cnt;
    rda_d      = 1'b0;
    wr_en_d    = 1'b0;
    scroll_d   = 1'b0;
    clr_busy_d = 1'b0;
    wr_data_d  = wr_data;
    col_d      = cur_col;
    row_d      = cur_row;
    if (clr_scr) begin
      state_d    = CLEAR;
      clr_cnt_d  = '0;
      clr_busy_d = 1'b1;
      col_d      = '0;
      row_d      = '0;
    end else begin
      case (state)
        IDLE: begin
          rda_d = 1'b1;
          if (accept) begin
            char_d = din;
            nl_d   = (din == 7'h0D);
            rda_d  = 1'b0;
            if (din == 7'h0D)     state_d = ADVANCE;
            else if (din < 7'h20) state_d = IDLE;
            else                  state_d = WAIT_SLOT;
          end
        end
        WAIT_SLOT: begin
          if (cursor_slot) begin
            state_d   = WRITE;
            wr_en_d   = 1'b1;
            wr_data_d = (char_q >= 7'h60) ? (char_q & 7'h5F) : char_q;
          end
        end
        WRITE: state_d = ADVANCE;
        ADVANCE: begin
          if (nl_q || (cur_col == COL_LAST)) begin
            col_d = '0;
            if (cur_row == ROW_LAST) begin
              scroll_d = 1'b1;
              state_d  = SCROLL_WAIT;
            end else begin
              row_d   = cur_row + 5'd1;
              rda_d   = 1'b1;
              state_d = IDLE;
            end
          end else begin
            col_d   = cur_col + 6'd1;
            rda_d   = 1'b1;
            state_d = IDLE;
          end
        end
        SCROLL_WAIT: begin
          if (scroll_done) begin
            rda_d   = 1'b1;
            state_d = IDLE;
          end
        end
        CLEAR: begin
          clr_busy_d = 1'b1;
          if (line_end) begin
            if (clr_cnt == CNT_LAST) begin
              clr_busy_d = 1'b0;
              clr_cnt_d  = '0;
              rda_d      = 1'b1;
              state_d    = IDLE;
            end else begin
              clr_cnt_d = clr_cnt + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      da_q     <= 1'b0;
      nl_q     <= 1'b0;
      char_q   <= '0;
      clr_cnt  <= '0;
      rda      <= 1'b0;
      wr_en    <= 1'b0;
      wr_data  <= '0;
      scroll   <= 1'b0;
      clr_busy <= 1'b0;
      cur_col  <= '0;
      cur_row  <= '0;
    end else begin
      state    <= state_d;
      da_q     <= da;
      nl_q     <= nl_d;
      char_q   <= char_d;
      clr_cnt  <= clr_cnt_d;
      rda      <= rda_d;
      wr_en    <= wr_en_d;
      wr_data  <= wr_data_d;
      scroll   <= scroll_d;
      clr_busy <= clr_busy_d;
      cur_col  <= col_d;
      cur_row  <= row_d;
    end
  end

`ifdef CURSOR_BLINK_EN
  localparam int unsigned BW = $clog2(BLINK_FRAMES + 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [BW-1:0] blink_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt  <= '0;
      cursor_vis <= 1'b1;
    end else if (state == WRITE) begin
      blink_cnt  <= '0;
      cursor_vis <= 1'b1;
    end else if (frame_tick) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt  <= '0;
        cursor_vis <= ~cursor_vis;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end
`else
  localparam int unsigned unused_blink_frames = BLINK_FRAMES;
  logic unused_frame_tick;
  assign unused_frame_tick = frame_tick;
  assign cursor_vis = 1'b1;
`endif

endmodule

// File: tb/tb_term_write_ctrl.sv
// Self-checking bench for term_write_ctrl: vector table, hand-written corner sequences
// and randomized characters checked against a linear-position cursor model.
module tb_term_write_ctrl;
  localparam int COLS = 40;
  localparam int ROWS = 24;
  localparam int BLINK_FRAMES = 30;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       da = 1'b0;
  logic [6:0] din = '0;
  logic       cursor_slot = 1'b0;
  logic       line_end = 1'b0;
  logic       scroll_done = 1'b0;
  logic       clr_scr = 1'b0;
  logic       frame_tick = 1'b0;
  logic       rda, wr_en, scroll, clr_busy, cursor_vis;
  logic [6:0] wr_data;
  logic [5:0] cur_col;
  logic [4:0] cur_row;

  term_write_ctrl #(.COLS(COLS), .ROWS(ROWS), .BLINK_FRAMES(BLINK_FRAMES)) dut (
    .clk(clk), .reset(reset), .da(da), .din(din), .cursor_slot(cursor_slot),
    .line_end(line_end), .scroll_done(scroll_done), .clr_scr(clr_scr),
    .frame_tick(frame_tick), .rda(rda), .wr_en(wr_en), .wr_data(wr_data),
    .cur_col(cur_col), .cur_row(cur_row), .scroll(scroll), .clr_busy(clr_busy),
    .cursor_vis(cursor_vis)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;
  int wr_cnt = 0;
  int scroll_cnt = 0;
  logic [6:0] last_wr = '0;
  int pos = 0;  // model cursor as row*COLS+col

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wr_cnt++;
      last_wr = wr_data;
    end
    if (scroll === 1'b1) scroll_cnt++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    failed++;
    $display("FAIL %s: got timeout expected DUT response", name);
  endtask

  task automatic wait_rda();
    int n;
    n = 0;
    while (rda !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (rda !== 1'b1) timeout_fail("rda_ready");
  endtask

  // Hand one character over and service slot/scroll_done until rda returns.
  task automatic send(input logic [6:0] c, input int hold);
    int n;
    wait_rda();
    din = c;
    da  = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      da          = (n < hold);
      cursor_slot = (n % 3 == 2);
      scroll_done = (scroll === 1'b1);
    end while (rda !== 1'b1 && n < 200);
    da = 1'b0;
    cursor_slot = 1'b0;
    scroll_done = 1'b0;
    if (rda !== 1'b1) timeout_fail("send_done");
    @(negedge clk);
  endtask

  task automatic send_check(input logic [6:0] c);
    int w0, s0, exp_w, exp_s, npos;
    logic [6:0] exp_d;
    w0 = wr_cnt;
    s0 = scroll_cnt;
    exp_w = 0;
    exp_s = 0;
    exp_d = '0;
    if (c == 7'h0D) npos = (pos / COLS + 1) * COLS;
    else if (c < 7'h20) npos = pos;
    else begin
      npos = pos + 1;
      exp_w = 1;
      exp_d = (c >= 7'h60) ? c - 7'h20 : c;
    end
    if (npos >= COLS * ROWS) begin
      npos = (ROWS - 1) * COLS;
      exp_s = 1;
    end
    pos = npos;
    send(c, int'($urandom_range(1, 3)));
    check("model_wr_count", wr_cnt - w0, exp_w);
    if (exp_w == 1) check("model_wr_data", last_wr, exp_d);
    check("model_scroll_count", scroll_cnt - s0, exp_s);
    check("model_col", cur_col, pos % COLS);
    check("model_row", cur_row, pos / COLS);
  endtask

  task automatic pulse_line_end();
    line_end = 1'b1;
    @(negedge clk);
    line_end = 1'b0;
    @(negedge clk);
  endtask

  task automatic clear_home();
    clr_scr = 1'b1;
    @(negedge clk);
    clr_scr = 1'b0;
    repeat (ROWS) pulse_line_end();
    pos = 0;
  endtask

  typedef struct {
    logic [6:0] din;
    logic       exp_wr;
    logic [6:0] exp_data;
    int         exp_col;
    int         exp_row;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int bad, w0, n;
    logic [6:0] c;
    int r;

    tbl[0] = '{7'h41, 1'b1, 7'h41, 1, 0};
    tbl[1] = '{7'h61, 1'b1, 7'h41, 2, 0};
    tbl[2] = '{7'h07, 1'b0, 7'h00, 2, 0};
    tbl[3] = '{7'h0D, 1'b0, 7'h00, 0, 1};
    tbl[4] = '{7'h7A, 1'b1, 7'h5A, 1, 1};
    tbl[5] = '{7'h20, 1'b1, 7'h20, 2, 1};
    tbl[6] = '{7'h1F, 1'b0, 7'h00, 2, 1};
    tbl[7] = '{7'h5F, 1'b1, 7'h5F, 3, 1};
    tbl[8] = '{7'h60, 1'b1, 7'h40, 4, 1};
    tbl[9] = '{7'h00, 1'b0, 7'h00, 4, 1};

    // Reset values, with da already high across reset release
    da = 1'b1;
    din = 7'h41;
    repeat (3) @(negedge clk);
    check("rst_rda", rda, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_scroll", scroll, 0);
    check("rst_clr_busy", clr_busy, 0);
    check("rst_cursor_vis", cursor_vis, 1);
    check("rst_col", cur_col, 0);
    check("rst_row", cur_row, 0);
    reset = 1'b0;
    @(negedge clk);
    check("rda_after_reset", rda, 1);
    repeat (3) @(negedge clk);
    check("held_da_not_accepted", rda, 1);
    da = 1'b0;
    @(negedge clk);

    // Accept / write / advance timing
    wait_rda();
    din = 7'h41;
    da = 1'b1;
    @(negedge clk);
    check("accept_rda_drop", rda, 0);
    repeat (4) @(negedge clk);
    cursor_slot = 1'b1;
    @(negedge clk);
    cursor_slot = 1'b0;
    check("write_strobe", wr_en, 1);
    check("write_data", wr_data, 7'h41);
    check("write_col_before", cur_col, 0);
    @(negedge clk);
    check("write_one_cycle", wr_en, 0);
    check("advance_rda_low", rda, 0);
    @(negedge clk);
    check("rda_back", rda, 1);
    check("advance_col", cur_col, 1);
    check("advance_row", cur_row, 0);
    repeat (3) @(negedge clk);
    check("da_held_no_retrigger", rda, 1);
    da = 1'b0;
    @(negedge clk);
    pos = 1;

    // Clear during WAIT_SLOT with cursor_slot competing
    w0 = wr_cnt;
    wait_rda();
    din = 7'h43;
    da = 1'b1;
    @(negedge clk);
    da = 1'b0;
    clr_scr = 1'b1;
    cursor_slot = 1'b1;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (clr_busy !== 1'b1 || wr_en !== 1'b0 || rda !== 1'b0) bad = 1;
    end
    clr_scr = 1'b0;
    cursor_slot = 1'b0;
    check("clear_hold", bad, 0);
    check("clear_col", cur_col, 0);
    check("clear_row", cur_row, 0);
    bad = 0;
    for (int i = 0; i < ROWS - 1; i++) begin
      pulse_line_end();
      if (clr_busy !== 1'b1 || rda !== 1'b0) bad = 1;
    end
    check("clear_busy_during_count", bad, 0);
    pulse_line_end();
    check("clear_done_busy", clr_busy, 0);
    check("clear_done_rda", rda, 1);
    check("clear_no_write", wr_cnt - w0, 0);
    pos = 0;

    // Vector table from home position
    for (int i = 0; i < 10; i++) begin
      w0 = wr_cnt;
      send(tbl[i].din, 1);
      check("tbl_wr_count", wr_cnt - w0, tbl[i].exp_wr);
      if (tbl[i].exp_wr == 1'b1) check("tbl_wr_data", last_wr, tbl[i].exp_data);
      check("tbl_col", cur_col, tbl[i].exp_col);
      check("tbl_row", cur_row, tbl[i].exp_row);
    end
    pos = 1 * COLS + 4;

    // Clear restart: reasserting clr_scr discards the partial line count
    clr_scr = 1'b1;
    @(negedge clk);
    clr_scr = 1'b0;
    repeat (10) pulse_line_end();
    clr_scr = 1'b1;
    line_end = 1'b1;
    @(negedge clk);
    clr_scr = 1'b0;
    line_end = 1'b0;
    repeat (ROWS - 1) pulse_line_end();
    check("clear_restart_busy", clr_busy, 1);
    pulse_line_end();
    check("clear_restart_done", clr_busy, 0);
    pos = 0;

    // Row wrap at column 39, then newline
    repeat (3) send_check(7'h0D);
    repeat (COLS - 1) send_check(7'h2E);
    check("wrap_pre_col", cur_col, 39);
    send_check(7'h42);
    check("wrap_col", cur_col, 0);
    check("wrap_row", cur_row, 4);
    send_check(7'h0D);
    check("newline_col", cur_col, 0);
    check("newline_row", cur_row, 5);

    // Scroll on newline from the bottom row
    clear_home();
    repeat (ROWS - 1) send_check(7'h0D);
    repeat (5) send_check(7'h58);
    w0 = scroll_cnt;
    wait_rda();
    din = 7'h0D;
    da = 1'b1;
    @(negedge clk);
    da = 1'b0;
    n = 0;
    while (scroll !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("scroll_pulse", scroll, 1);
    check("scroll_col", cur_col, 0);
    check("scroll_row", cur_row, 23);
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (rda !== 1'b0 || scroll !== 1'b0) bad = 1;
    end
    check("scroll_wait_hold", bad, 0);
    scroll_done = 1'b1;
    @(negedge clk);
    scroll_done = 1'b0;
    check("scroll_done_rda", rda, 1);
    check("scroll_single", scroll_cnt - w0, 1);
    pos = (ROWS - 1) * COLS;
    @(negedge clk);

    // Randomized characters against the position model
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 25) c = 7'h0D;
      else if (r < 35) c = 7'($urandom_range(0, 31));
      else c = 7'($urandom_range(32, 127));
      send_check(c);
    end

`ifdef CURSOR_BLINK_EN
    send_check(7'h41);
    for (int i = 1; i <= 60; i++) begin
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      @(negedge clk);
      if (i == 29) check("blink_29", cursor_vis, 1);
      if (i == 30) check("blink_30", cursor_vis, 0);
      if (i == 59) check("blink_59", cursor_vis, 0);
      if (i == 60) check("blink_60", cursor_vis, 1);
    end
    send_check(7'h41);
    repeat (40) begin
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      @(negedge clk);
    end
    check("blink_40", cursor_vis, 0);
    send_check(7'h42);
    check("blink_write_forces", cursor_vis, 1);
    for (int i = 1; i <= 30; i++) begin
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      @(negedge clk);
      if (i == 29) check("blink_restart_29", cursor_vis, 1);
      if (i == 30) check("blink_restart_30", cursor_vis, 0);
    end
`else
    repeat (40) begin
      frame_tick = 1'b1;
      @(negedge clk);
    end
    frame_tick = 1'b0;
    check("cursor_vis_const", cursor_vis, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
